// File: rtl/cpu_pkg.sv
// Shared decode-stage definitions: immediate format codes, opcodes, state enum.
package cpu_pkg;

    // Immediate format selector; each code repeats its 3-bit index twice.
    typedef enum logic [5:0] {
        IMM_I     = 6'b000000,
        IMM_S     = 6'b001001,
        IMM_B     = 6'b010010,
        IMM_U     = 6'b011011,
        IMM_J     = 6'b100100,
        IMM_SHAMT = 6'b101101,
        IMM_ZIMM  = 6'b110110
    } imm_sel_e;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // Occupancy of the main/skid buffer pair.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } dec_state_e;

    // One decoded entry as held in the main or skid register.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        imm_sel_e    imm_sel;
        logic        illegal;
    } dec_entry_t;

endpackage

// File: rtl/imm_decoder.sv
// Combinational opcode decoder: instruction -> immediate format and illegal flag.
module imm_decoder
    import cpu_pkg::*;
(
    input  logic [31:0] instr,
    output imm_sel_e    imm_sel,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       unused_bits;

    assign opcode      = instr[6:0];
    assign funct3      = instr[14:12];
    assign unused_bits = ^{instr[31:15], instr[11:7]};

    // Map opcode (and funct3 where it matters) to the immediate format.
    always_comb begin
        imm_sel = IMM_I;
        illegal = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_JALR:     imm_sel = IMM_I;
            OPC_OP_IMM:             imm_sel = (funct3 == 3'b001 || funct3 == 3'b101) ? IMM_SHAMT : IMM_I;
            OPC_STORE:              imm_sel = IMM_S;
            OPC_BRANCH:             imm_sel = IMM_B;
            OPC_LUI, OPC_AUIPC:     imm_sel = IMM_U;
            OPC_JAL:                imm_sel = IMM_J;
            OPC_SYSTEM:             imm_sel = funct3[2] ? IMM_ZIMM : IMM_I;
            OPC_OP, OPC_MISC_MEM:   imm_sel = IMM_I;
            default:                illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage with a two-entry (main + skid) buffer so if_ready is a pure register.
module decode_stage
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [5:0]  id_imm_sel,
    output logic [4:0]  id_rs1,
    output logic [4:0]  id_rs2,
    output logic [4:0]  id_rd,
    output logic        id_illegal
);

    dec_state_e state_q, state_d;
    dec_entry_t main_q, main_d;
    dec_entry_t skid_q, skid_d;
    logic       if_ready_q, if_ready_d;
    logic       id_valid_q, id_valid_d;

    imm_sel_e   dec_imm_sel;
    logic       dec_illegal;
    dec_entry_t in_entry;
    logic       accept;
    logic       consume;

    imm_decoder u_imm_decoder (
        .instr   (if_instr),
        .imm_sel (dec_imm_sel),
        .illegal (dec_illegal)
    );

    assign in_entry = '{instr: if_instr, pc: if_pc, imm_sel: dec_imm_sel, illegal: dec_illegal};
    assign accept   = if_valid & if_ready_q;
    assign consume  = id_valid_q & id_ready;

    // Next occupancy and buffer contents from this cycle's accept/consume.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_d  = in_entry;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && consume) begin
                    main_d = in_entry;
                end else if (accept) begin
                    skid_d  = in_entry;
                    state_d = ST_TWO;
                end else if (consume) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (consume) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush wins over any same-cycle accept; buffered data is simply invalidated.
        if (flush) begin
            state_d = ST_EMPTY;
        end
        if_ready_d = (state_d != ST_TWO);
        id_valid_d = (state_d != ST_EMPTY);
    end

    // State and buffer registers; reset overrides flush and all transfers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            if_ready_q <= 1'b1;
            id_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            if_ready_q <= if_ready_d;
            id_valid_q <= id_valid_d;
        end
    end

    assign if_ready   = if_ready_q;
    assign id_valid   = id_valid_q;
    assign id_instr   = main_q.instr;
    assign id_pc      = main_q.pc;
    assign id_imm_sel = main_q.imm_sel;
    assign id_illegal = main_q.illegal;
    assign id_rs1     = main_q.instr[19:15];
    assign id_rs2     = main_q.instr[24:20];
    assign id_rd      = main_q.instr[11:7];

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic vs a queue model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset, flush, if_valid, id_ready;
    logic        if_ready, id_valid, id_illegal;
    logic [31:0] if_instr, if_pc, id_instr, id_pc;
    logic [5:0]  id_imm_sel;
    logic [4:0]  id_rs1, id_rs2, id_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_instr   (id_instr),
        .id_pc      (id_pc),
        .id_imm_sel (id_imm_sel),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_rd      (id_rd),
        .id_illegal (id_illegal)
    );

    // Reference model: a bounded FIFO of (instr, pc) of capacity two.
    logic [31:0] mq_instr[$];
    logic [31:0] mq_pc[$];

    always @(posedge clk) begin
        bit acc, con;
        acc = if_valid && (mq_instr.size() < 2);
        con = id_ready && (mq_instr.size() > 0);
        if (reset || flush) begin
            mq_instr.delete();
            mq_pc.delete();
        end else begin
            if (con) begin
                void'(mq_instr.pop_front());
                void'(mq_pc.pop_front());
            end
            if (acc) begin
                mq_instr.push_back(if_instr);
                mq_pc.push_back(if_pc);
            end
        end
    end

    function automatic logic [5:0] ref_imm(input logic [31:0] ins);
        logic [6:0] op;
        logic [2:0] f3;
        op = ins[6:0];
        f3 = ins[14:12];
        if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) return 6'b101101;
        if (op == 7'h23) return 6'b001001;
        if (op == 7'h63) return 6'b010010;
        if (op == 7'h37 || op == 7'h17) return 6'b011011;
        if (op == 7'h6F) return 6'b100100;
        if (op == 7'h73 && f3[2]) return 6'b110110;
        return 6'b000000;
    endfunction

    function automatic logic ref_illegal(input logic [31:0] ins);
        logic [6:0] op;
        op = ins[6:0];
        return !(op inside {7'h03, 7'h67, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h33, 7'h0F});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
        if_instr = '0; if_pc = '0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid got %0b want 0", id_valid); end
        checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL reset_if_ready got %0b want 1", if_ready); end
        checks++; if (id_imm_sel !== 6'b0 || id_illegal !== 1'b0) begin errors++; $display("FAIL reset_sel got %b/%0b want 000000/0", id_imm_sel, id_illegal); end
        checks++; if ({id_instr, id_pc, id_rs1, id_rs2, id_rd} !== '0) begin errors++; $display("FAIL reset_data got %h %h %0d %0d %0d want zeros", id_instr, id_pc, id_rs1, id_rs2, id_rd); end
    endtask

    task automatic test_basic();
        idle();
        id_ready = 1'b1; if_valid = 1'b1; if_instr = 32'h00500093; if_pc = 32'h0000_1000;
        step();
        if_valid = 1'b0;
        checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b want 1", id_valid); end
        checks++; if (id_imm_sel !== 6'b000000) begin errors++; $display("FAIL basic_sel got %b want 000000", id_imm_sel); end
        checks++; if (id_rd !== 5'd1 || id_rs1 !== 5'd0) begin errors++; $display("FAIL basic_regs got rd=%0d rs1=%0d want 1/0", id_rd, id_rs1); end
        checks++; if (id_illegal !== 1'b0 || id_pc !== 32'h0000_1000) begin errors++; $display("FAIL basic_misc got ill=%0b pc=%h want 0/00001000", id_illegal, id_pc); end
        step();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %0b want 0", id_valid); end
    endtask

    task automatic test_stream();
        logic [31:0] ins[5] = '{32'h00209113, 32'h00112223, 32'hFE000EE3, 32'h000012B7, 32'h0080006F};
        logic [5:0]  exp[5] = '{6'b101101, 6'b001001, 6'b010010, 6'b011011, 6'b100100};
        idle();
        id_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if_valid = 1'b1; if_instr = ins[i]; if_pc = 32'h200 + 4 * i;
            step();
            checks++;
            if (id_valid !== 1'b1 || id_imm_sel !== exp[i] || id_instr !== ins[i] || if_ready !== 1'b1)
                begin errors++; $display("FAIL stream_%0d got v=%0b sel=%b ins=%h rdy=%0b want 1/%b/%h/1", i, id_valid, id_imm_sel, id_instr, if_ready, exp[i], ins[i]); end
        end
        if_valid = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        idle();
        if_valid = 1'b1; if_instr = 32'h00A00113; if_pc = 32'h300;
        step();
        checks++; if (if_ready !== 1'b1 || id_instr !== 32'h00A00113) begin errors++; $display("FAIL bp_first got rdy=%0b ins=%h want 1/00a00113", if_ready, id_instr); end
        if_instr = 32'h00B00193; if_pc = 32'h304;
        step();
        if_valid = 1'b0;
        checks++; if (if_ready !== 1'b0 || id_instr !== 32'h00A00113 || id_valid !== 1'b1) begin errors++; $display("FAIL bp_full got rdy=%0b ins=%h want 0/00a00113", if_ready, id_instr); end
        step();
        checks++; if (id_instr !== 32'h00A00113 || id_pc !== 32'h300) begin errors++; $display("FAIL bp_stable got ins=%h pc=%h want 00a00113/300", id_instr, id_pc); end
        id_ready = 1'b1;
        step();
        checks++; if (id_valid !== 1'b1 || id_instr !== 32'h00B00193 || if_ready !== 1'b1) begin errors++; $display("FAIL bp_second got v=%0b ins=%h rdy=%0b want 1/00b00193/1", id_valid, id_instr, if_ready); end
        step();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %0b want 0", id_valid); end
    endtask

    task automatic test_flush();
        idle();
        if_valid = 1'b1; if_instr = 32'h00100093; step();
        if_instr = 32'h00200113; step();
        flush = 1'b1; if_instr = 32'hDEADB0B7; if_pc = 32'hBAD0;
        step();
        flush = 1'b0; if_valid = 1'b0;
        checks++; if (id_valid !== 1'b0 || if_ready !== 1'b1) begin errors++; $display("FAIL flush_state got v=%0b rdy=%0b want 0/1", id_valid, if_ready); end
        id_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL flush_leak_%0d got v=%0b ins=%h want 0", i, id_valid, id_instr); end
        end
    endtask

    task automatic test_illegal();
        idle();
        id_ready = 1'b1; if_valid = 1'b1; if_instr = 32'h00000000;
        step();
        checks++; if (id_illegal !== 1'b1 || id_imm_sel !== 6'b000000) begin errors++; $display("FAIL illegal_zero got ill=%0b sel=%b want 1/000000", id_illegal, id_imm_sel); end
        if_instr = 32'h3400D073;
        step();
        if_valid = 1'b0;
        checks++; if (id_illegal !== 1'b0 || id_imm_sel !== 6'b110110) begin errors++; $display("FAIL illegal_csrrwi got ill=%0b sel=%b want 0/110110", id_illegal, id_imm_sel); end
        step();
    endtask

    task automatic test_reset_mid();
        idle();
        if_valid = 1'b1; if_instr = 32'h0080006F; if_pc = 32'h440;
        step();
        reset = 1'b1; if_instr = 32'h00112223; id_ready = 1'b1;
        step();
        reset = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
        checks++; if (id_valid !== 1'b0 || if_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ctl got v=%0b rdy=%0b want 0/1", id_valid, if_ready); end
        checks++; if ({id_instr, id_pc, id_imm_sel, id_rs1, id_rs2, id_rd, id_illegal} !== '0) begin errors++; $display("FAIL rstmid_data got ins=%h pc=%h sel=%b want zeros", id_instr, id_pc, id_imm_sel); end
    endtask

    task automatic test_random();
        logic [6:0] ops[12] = '{7'h03, 7'h67, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h33, 7'h0F, 7'h00};
        idle();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if_valid = ($urandom_range(0, 99) < 70);
            id_ready = ($urandom_range(0, 99) < 60);
            flush    = ($urandom_range(0, 99) < 3);
            reset    = ($urandom_range(0, 199) < 2);
            if_instr = $urandom;
            if ($urandom_range(0, 9) != 0) if_instr[6:0] = ops[$urandom_range(0, 11)];
            if_pc = $urandom;
            step();
            checks++;
            if (id_valid !== (mq_instr.size() > 0) || if_ready !== (mq_instr.size() < 2))
                begin errors++; $display("FAIL rand_ctl cyc %0d got v=%0b rdy=%0b want v=%0b rdy=%0b", cyc, id_valid, if_ready, mq_instr.size() > 0, mq_instr.size() < 2); end
            if (mq_instr.size() > 0) begin
                checks++;
                if (id_instr !== mq_instr[0] || id_pc !== mq_pc[0] || id_imm_sel !== ref_imm(mq_instr[0]) ||
                    id_illegal !== ref_illegal(mq_instr[0]) || id_rs1 !== mq_instr[0][19:15] ||
                    id_rs2 !== mq_instr[0][24:20] || id_rd !== mq_instr[0][11:7])
                    begin errors++; $display("FAIL rand_data cyc %0d got ins=%h pc=%h sel=%b ill=%0b want ins=%h pc=%h sel=%b ill=%0b", cyc, id_instr, id_pc, id_imm_sel, id_illegal, mq_instr[0], mq_pc[0], ref_imm(mq_instr[0]), ref_illegal(mq_instr[0])); end
            end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_basic();
        test_stream();
        test_back_to_back();
        test_flush();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port flush, input, 1 bit: discard all held instructions.
REQ-004 SHALL have port if_valid, input, 1 bit: fetch offers an instruction.
REQ-005 SHALL have port if_ready, output, 1 bit: the stage accepts an instruction this cycle.
REQ-006 SHALL have port if_instr, input, 32 bits: the raw instruction.
REQ-007 SHALL have port if_pc, input, 32 bits: the instruction address.
REQ-008 SHALL have port id_valid, output, 1 bit: decoded entry available.
REQ-009 SHALL have port id_ready, input, 1 bit: the immediate/execute side consumes.
REQ-010 SHALL have port id_instr, output, 32 bits: the held instruction.
REQ-011 SHALL have port id_pc, output, 32 bits: the held address.
REQ-012 SHALL have port id_imm_sel, output, 6 bits: immediate format code.
REQ-013 SHALL have ports id_rs1, id_rs2 and id_rd, outputs, 5 bits each: register indices, taken from instr[19:15], [24:20] and [11:7].
REQ-014 SHALL have port id_illegal, output, 1 bit: unrecognised opcode.

Function
REQ-015 SHALL use imm_sel codes I=000000, S=001001, B=010010, U=011011, J=100100, SHAMT=101101, ZIMM=110110.
REQ-016 SHALL decode imm_sel from opcode instr[6:0] as follows:
- 0000011 (load) and 1100111 (JALR) -> I.
- 0010011 (OP-IMM) -> SHAMT when funct3 is 001 or 101, otherwise I.
- 0100011 (store) -> S.
- 1100011 (branch) -> B.
- 0110111 (LUI) and 0010111 (AUIPC) -> U.
- 1101111 (JAL) -> J.
- 1110011 (SYSTEM) -> ZIMM when funct3[2]=1, otherwise I.
- 0110011, 0001111 -> I, with illegal=0.
- Any other opcode -> I with illegal=1.
REQ-017 SHALL perform decode before registering; all id_* outputs are register outputs, giving 1-cycle latency from accept to id_valid.
REQ-018 SHALL define a transfer as valid&ready high on the same edge, on either side.
REQ-019 SHALL hold two entries, main and skid, with states EMPTY, ONE and TWO.
REQ-020 SHALL drive if_ready = (state != TWO) as a registered signal; it depends on no combinational input.
REQ-021 SHALL sustain full throughput of 1 instruction/cycle when id_ready is held high.
REQ-022 SHALL use these state transitions:
- EMPTY + accept -> ONE.
- ONE + accept without consume -> TWO, new entry into skid.
- ONE + accept and consume -> ONE, main replaced.
- ONE + consume only -> EMPTY.
- TWO + consume -> ONE, skid moves to main.
- TWO never accepts.
REQ-023 SHALL keep id_* outputs stable while id_valid=1 and id_ready=0.
REQ-024 SHALL, on flush, go to EMPTY on the next edge; flush beats a same-cycle accept, and the accepted instruction is dropped.
REQ-025 SHALL have reset take priority over flush and over all transfers.

Reset
REQ-026 SHALL, on reset, set state=EMPTY, id_valid=0, if_ready=1, id_imm_sel=000000, id_illegal=0, and id_instr, id_pc and register indices to 0.
REQ-027 SHALL apply reset mid-operation on the next edge, discarding both entries; no transfer completes on that edge.

Structure
REQ-028 SHALL place the imm_sel codes, opcode constants and the state enum in a shared package, cpu_pkg.
REQ-029 SHALL put the combinational decoder in one sub-module, imm_decoder, mapping instr to imm_sel and illegal; it is instantiated once on the input path.

Verification
REQ-030 SHALL cover: push 0x00500093 with id_ready=1 -> next cycle id_valid=1, imm_sel=000000, rd=1, rs1=0, illegal=0.
REQ-031 SHALL cover: stream 0x00209113, 0x00112223, 0xFE000EE3, 0x000012B7, 0x0080006F -> imm_sel 101101, 001001, 010010, 011011, 100100 on consecutive cycles, no bubbles.
REQ-032 SHALL cover: id_ready=0, push 2 instructions -> if_ready=0 after the 2nd; then id_ready=1 -> both emerge in order, if_ready returns to 1.
REQ-033 SHALL cover: state TWO, assert flush with if_valid=1 -> next cycle id_valid=0, if_ready=1, the pushed instruction is never output.
REQ-034 SHALL cover: push 0x00000000 -> illegal=1, imm_sel=000000; push 0x3400D073 (csrrwi) -> imm_sel=110110.
REQ-035 SHALL cover: reset asserted while in state ONE with if_valid=1 -> next cycle id_valid=0, if_ready=1, all outputs at reset values.
